// File: rtl/nco_row_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nco_row_sched_pkg
// Brief    : Shared state encoding and widths for the NCO row scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package nco_row_sched_pkg;

    localparam int NCO_LAT   = 6;
    localparam int V_POS_W   = 9;
    localparam int BLK_IDX_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_PRIME    = 3'd2,
        ST_RUN      = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nco_row_timer.sv
`default_nettype none
// ============================================================================
// Module   : nco_row_timer
// Brief    : Loadable down-counter with terminal-count flag (count == 0).
// Revision : 1.0 - initial release
// ============================================================================
module nco_row_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // Saturates at zero so an idle timer keeps reporting terminal count.
    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (r_count_q != '0) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_tc    = (r_count_q == '0);

endmodule
`default_nettype wire

// File: rtl/nco_row_sched.sv
`default_nettype none
// ============================================================================
// Module   : nco_row_sched
// Brief    : Sequences the 4-channel NCO over spectrogram rows: START pulse,
//            priming wait, valid-block window, inter-row gap.
//            Optional ABORT input enabled by NCO_ROW_SCHED_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nco_row_sched
    import nco_row_sched_pkg::*;
#(
    parameter int N_ROWS         = 480,
    parameter int BLOCKS_PER_ROW = 64,
    parameter int ROW_GAP        = 2
) (
    input  logic                 CK,
    input  logic                 RST_N,
    input  logic                 FRAME_GO,
    input  logic                 MODE_SEL,
    input  logic                 ACC_READY,
`ifdef NCO_ROW_SCHED_ABORT_EN
    input  logic                 ABORT,
`endif
    output logic                 NCO_START,
    output logic [V_POS_W-1:0]   V_POS,
    output logic                 MODE_4800,
    output logic                 BLK_VALID,
    output logic [BLK_IDX_W-1:0] BLK_IDX,
    output logic                 ROW_LAST_BLK,
    output logic                 FRAME_DONE,
    output logic                 BUSY
);

    localparam logic [BLK_IDX_W-1:0] c_prime_load = BLK_IDX_W'(NCO_LAT - 2);
    localparam logic [BLK_IDX_W-1:0] c_run_load   = BLK_IDX_W'(BLOCKS_PER_ROW - 1);
    localparam logic [BLK_IDX_W-1:0] c_gap_load   = BLK_IDX_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
    localparam logic [V_POS_W-1:0]   c_last_row   = V_POS_W'(N_ROWS - 1);

    state_t                 r_state_q;
    state_t                 w_state_d;
    logic [V_POS_W-1:0]     r_vpos_q;
    logic [V_POS_W-1:0]     w_vpos_d;
    logic                   r_mode_q;
    logic                   w_mode_d;
    logic                   w_tmr_load;
    logic [BLK_IDX_W-1:0]   w_tmr_val;
    logic [BLK_IDX_W-1:0]   w_tmr_count;
    logic                   w_tmr_tc;
    logic                   w_abort;

`ifdef NCO_ROW_SCHED_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    nco_row_timer #(
        .WIDTH (BLK_IDX_W)
    ) u_timer (
        .clk        (CK),
        .rst_n      (RST_N),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_count    (w_tmr_count),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // The START cycle itself is spent in WAIT_RDY, so PRIME is loaded one short.
    always_comb begin
        w_state_d  = r_state_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (FRAME_GO) begin
                    w_state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (ACC_READY) begin
                    w_state_d  = ST_PRIME;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_prime_load;
                end
            end
            ST_PRIME: begin
                if (w_tmr_tc) begin
                    w_state_d  = ST_RUN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_run_load;
                end
            end
            ST_RUN: begin
                if (w_tmr_tc) begin
                    if (r_vpos_q == c_last_row) begin
                        w_state_d = ST_DONE;
                    end else if (ROW_GAP == 0) begin
                        w_state_d = ST_WAIT_RDY;
                    end else begin
                        w_state_d  = ST_GAP;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_gap_load;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_tc) begin
                    w_state_d = ST_WAIT_RDY;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        if (w_abort && (r_state_q != ST_IDLE) && (r_state_q != ST_DONE)) begin
            w_state_d = ST_DONE;
        end
    end

    // Row address moves only on accept, on leaving RUN, or on entering DONE.
    always_comb begin
        w_vpos_d = r_vpos_q;
        w_mode_d = r_mode_q;
        if ((r_state_q == ST_IDLE) && FRAME_GO) begin
            w_vpos_d = '0;
            w_mode_d = MODE_SEL;
        end else if ((w_state_d == ST_DONE) && (r_state_q != ST_DONE)) begin
            w_vpos_d = '0;
        end else if ((r_state_q == ST_RUN) && w_tmr_tc) begin
            w_vpos_d = r_vpos_q + 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            r_vpos_q <= '0;
            r_mode_q <= 1'b0;
        end else begin
            r_vpos_q <= w_vpos_d;
            r_mode_q <= w_mode_d;
        end
    end

    always_comb begin
        NCO_START    = (r_state_q == ST_WAIT_RDY) && ACC_READY && !w_abort;
        BLK_VALID    = (r_state_q == ST_RUN) && !w_abort;
        ROW_LAST_BLK = (r_state_q == ST_RUN) && w_tmr_tc && !w_abort;
        BLK_IDX      = '0;
        if (r_state_q == ST_RUN) begin
            BLK_IDX = c_run_load - w_tmr_count;
        end
        FRAME_DONE   = (r_state_q == ST_DONE);
        BUSY         = (r_state_q != ST_IDLE) || (FRAME_GO && RST_N);
        V_POS        = r_vpos_q;
        MODE_4800    = r_mode_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_nco_row_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_row_sched
// Brief    : Scoreboard bench for nco_row_sched (default frame + 1-row build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_row_sched;

    localparam int PER = 72;
    localparam int NR  = 480;
    localparam int BPR = 64;

    typedef struct { int cyc; int vpos; int idx; bit last; bit mode; } ev_t;
    typedef struct { bit busy; bit start; bit valid; int idx; bit last; bit done; bit mode; } r1_t;

    logic CK = 1'b0, RST_N = 1'b0, FRAME_GO = 1'b0, MODE_SEL = 1'b0, ACC_READY = 1'b0;
    logic       NCO_START, MODE_4800, BLK_VALID, ROW_LAST_BLK, FRAME_DONE, BUSY;
    logic [8:0] V_POS;
    logic [9:0] BLK_IDX;
    logic go1 = 1'b0, msel1 = 1'b0, acc1 = 1'b1;
    logic       start1, mode1, valid1, last1, done1, busy1;
    logic [8:0] vpos1;
    logic [9:0] idx1;
`ifdef NCO_ROW_SCHED_ABORT_EN
    logic abort_m = 1'b0, abort1 = 1'b0;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  sq[$];
    ev_t  bq[$];
    ev_t  dq[$];
    r1_t  q1[$];

    nco_row_sched dut (
        .CK(CK), .RST_N(RST_N), .FRAME_GO(FRAME_GO), .MODE_SEL(MODE_SEL), .ACC_READY(ACC_READY),
`ifdef NCO_ROW_SCHED_ABORT_EN
        .ABORT(abort_m),
`endif
        .NCO_START(NCO_START), .V_POS(V_POS), .MODE_4800(MODE_4800), .BLK_VALID(BLK_VALID),
        .BLK_IDX(BLK_IDX), .ROW_LAST_BLK(ROW_LAST_BLK), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    nco_row_sched #(.N_ROWS(1), .BLOCKS_PER_ROW(4), .ROW_GAP(2)) dut1 (
        .CK(CK), .RST_N(RST_N), .FRAME_GO(go1), .MODE_SEL(msel1), .ACC_READY(acc1),
`ifdef NCO_ROW_SCHED_ABORT_EN
        .ABORT(abort1),
`endif
        .NCO_START(start1), .V_POS(vpos1), .MODE_4800(mode1), .BLK_VALID(valid1),
        .BLK_IDX(idx1), .ROW_LAST_BLK(last1), .FRAME_DONE(done1), .BUSY(busy1)
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    initial begin
        #(70000 * 10);
        $display("FAIL watchdog: got cycle %0d, required finish before it", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_row(input int s, input int r, input bit m, input int nblk);
        sq.push_back('{cyc: s, vpos: r, idx: 0, last: 1'b0, mode: m});
        for (int b = 0; b < nblk; b++)
            bq.push_back('{cyc: s + 6 + b, vpos: r, idx: b, last: (b == BPR - 1), mode: m});
    endtask

    // Main scoreboard monitor: every presented output must match the queue head.
    always @(negedge CK) begin
        ev_t e;
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL start_missing: got none, required start at cycle %0d", sq[0].cyc);
            void'(sq.pop_front());
        end
        while (bq.size() > 0 && bq[0].cyc < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL blk_missing: got none, required row %0d blk %0d at cycle %0d",
                     bq[0].vpos, bq[0].idx, bq[0].cyc);
            void'(bq.pop_front());
        end
        while (dq.size() > 0 && dq[0].cyc < cyc) begin
            n_checks++; n_fail++;
            $display("FAIL done_missing: got none, required at cycle %0d", dq[0].cyc);
            void'(dq.pop_front());
        end
        if (NCO_START === 1'b1) begin
            n_checks++;
            if (sq.size() == 0) begin
                n_fail++;
                $display("FAIL start_unexpected: got start at cycle %0d, required none", cyc);
            end else begin
                e = sq.pop_front();
                if (e.cyc != cyc || int'(V_POS) != e.vpos || MODE_4800 !== e.mode) begin
                    n_fail++;
                    $display("FAIL start: got cyc=%0d vpos=%0d mode=%0b required cyc=%0d vpos=%0d mode=%0b",
                             cyc, V_POS, MODE_4800, e.cyc, e.vpos, e.mode);
                end
            end
        end
        if (BLK_VALID === 1'b1) begin
            n_checks++;
            if (bq.size() == 0) begin
                n_fail++;
                $display("FAIL blk_unexpected: got valid at cycle %0d vpos=%0d, required none", cyc, V_POS);
            end else begin
                e = bq.pop_front();
                if (e.cyc != cyc || int'(V_POS) != e.vpos || int'(BLK_IDX) != e.idx ||
                    ROW_LAST_BLK !== e.last || MODE_4800 !== e.mode) begin
                    n_fail++;
                    $display("FAIL blk: got cyc=%0d vpos=%0d idx=%0d last=%0b mode=%0b required cyc=%0d vpos=%0d idx=%0d last=%0b mode=%0b",
                             cyc, V_POS, BLK_IDX, ROW_LAST_BLK, MODE_4800, e.cyc, e.vpos, e.idx, e.last, e.mode);
                end
            end
        end else if (ROW_LAST_BLK === 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL last_without_valid: got row_last=1 valid=0 at cycle %0d, required row_last=0", cyc);
        end
        if (FRAME_DONE === 1'b1) begin
            n_checks++;
            if (dq.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got frame_done at cycle %0d, required none", cyc);
            end else begin
                e = dq.pop_front();
                if (e.cyc != cyc || V_POS !== 9'd0 || BUSY !== 1'b1 || MODE_4800 !== e.mode) begin
                    n_fail++;
                    $display("FAIL done: got cyc=%0d vpos=%0d busy=%0b mode=%0b required cyc=%0d vpos=0 busy=1 mode=%0b",
                             cyc, V_POS, BUSY, MODE_4800, e.cyc, e.mode);
                end
            end
        end
    end

    // Single-row instance monitor: one expected vector per cycle while queued.
    always @(negedge CK) begin
        r1_t x;
        if (q1.size() > 0) begin
            x = q1.pop_front();
            n_checks++;
            if ({busy1, start1, valid1, idx1, last1, done1, mode1, vpos1} !==
                {x.busy, x.start, x.valid, 10'(x.idx), x.last, x.done, x.mode, 9'd0}) begin
                n_fail++;
                $display("FAIL row1 cyc %0d: got busy=%0b start=%0b valid=%0b idx=%0d last=%0b done=%0b mode=%0b vpos=%0d required busy=%0b start=%0b valid=%0b idx=%0d last=%0b done=%0b mode=%0b vpos=0",
                         cyc, busy1, start1, valid1, idx1, last1, done1, mode1, vpos1,
                         x.busy, x.start, x.valid, x.idx, x.last, x.done, x.mode);
            end
        end
    end

    initial begin
        int g, s2, s, done_a, g2, c_rst, g3;
        @(posedge CK);
        @(negedge CK);
        check("reset_main", {NCO_START, V_POS, MODE_4800, BLK_VALID, BLK_IDX, ROW_LAST_BLK, FRAME_DONE, BUSY}, 0);
        check("reset_row1", {start1, vpos1, mode1, valid1, idx1, last1, done1, busy1}, 0);
        repeat (2) @(posedge CK);
        #1 RST_N = 1'b1;

        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge CK);
                    check("idle_outputs", {NCO_START, V_POS, MODE_4800, BLK_VALID, BLK_IDX,
                                           ROW_LAST_BLK, FRAME_DONE, BUSY}, 0);
                end
            end
            begin
                wait_cyc(10);
                go1 = 1'b1; msel1 = 1'b1;
                for (int c = 10; c < 24; c++)
                    q1.push_back('{busy: (c <= 21), start: (c == 11), valid: (c >= 17 && c <= 20),
                                   idx: (c >= 17 && c <= 20) ? c - 17 : 0, last: (c == 20),
                                   done: (c == 21), mode: (c >= 11)});
                wait_cyc(11);
                go1 = 1'b0; msel1 = 1'b0;
            end
        join

        // Full frame, band 4800, with a 50-cycle stall before row 3.
        g  = 120;
        s2 = g + 1 + 2 * PER;
        for (int r = 0; r < NR; r++) begin
            s = (r < 3) ? g + 1 + PER * r : s2 + 122 + PER * (r - 3);
            push_row(s, r, 1'b1, BPR);
        end
        done_a = s2 + 122 + PER * (NR - 4) + 70;
        dq.push_back('{cyc: done_a, vpos: 0, idx: 0, last: 1'b0, mode: 1'b1});
        wait_cyc(g);
        FRAME_GO = 1'b1; MODE_SEL = 1'b1; ACC_READY = 1'b1;
        @(negedge CK);
        check("busy_on_accept", BUSY, 1);
        wait_cyc(g + 1);
        FRAME_GO = 1'b0; MODE_SEL = 1'b0;
        for (int c = s2 + 6; c < s2 + 70; c++) begin
            wait_cyc(c);
            ACC_READY = c[0];
        end
        wait_cyc(s2 + 70);
        ACC_READY = 1'b0;
        wait_cyc(s2 + 122);
        ACC_READY = 1'b1;
        wait_cyc(g + 1000);
        FRAME_GO = 1'b1;
        @(negedge CK);
        check("busy_midframe", BUSY, 1);
        wait_cyc(g + 1001);
        FRAME_GO = 1'b0;
        wait_cyc(done_a + 1);
        @(negedge CK);
        check("after_done", {BUSY, V_POS, FRAME_DONE}, 0);
        check("mode_held", MODE_4800, 1);

        // Band 2400 frame, reset at block 30 of row 5.
        g2 = done_a + 10;
        for (int r = 0; r < 6; r++)
            push_row(g2 + 1 + PER * r, r, 1'b0, (r < 5) ? BPR : 31);
        c_rst = g2 + 1 + PER * 5 + 6 + 30;
        wait_cyc(g2);
        FRAME_GO = 1'b1; MODE_SEL = 1'b0;
        wait_cyc(g2 + 1);
        FRAME_GO = 1'b0;
        wait_cyc(c_rst);
        RST_N = 1'b0;
        wait_cyc(c_rst + 1);
        RST_N = 1'b1;
        @(negedge CK);
        check("reset_midrun", {NCO_START, V_POS, MODE_4800, BLK_VALID, BLK_IDX, ROW_LAST_BLK, FRAME_DONE, BUSY}, 0);

        // Restart after reset must begin at row 0 again.
        g3 = c_rst + 5;
        push_row(g3 + 1, 0, 1'b1, BPR);
        push_row(g3 + 1 + PER, 1, 1'b1, 10);
        wait_cyc(g3);
        FRAME_GO = 1'b1; MODE_SEL = 1'b1;
        wait_cyc(g3 + 1);
        FRAME_GO = 1'b0; MODE_SEL = 1'b0;
        wait_cyc(g3 + 1 + PER + 6 + 9);
        RST_N = 1'b0;
        wait_cyc(g3 + 1 + PER + 6 + 10);
        RST_N = 1'b1;
        @(negedge CK);
        check("reset_restart", {NCO_START, V_POS, MODE_4800, BLK_VALID, BLK_IDX, ROW_LAST_BLK, FRAME_DONE, BUSY}, 0);

`ifdef NCO_ROW_SCHED_ABORT_EN
        begin
            int t;
            t = cyc + 5;
            wait_cyc(t);
            go1 = 1'b1;
            wait_cyc(t + 1);
            go1 = 1'b0;
            wait_cyc(t + 8);
            @(negedge CK);
            check("abort_pre_valid", valid1, 1);
            wait_cyc(t + 9);
            abort1 = 1'b1;
            @(negedge CK);
            check("abort_valid_gated", {valid1, last1}, 0);
            wait_cyc(t + 10);
            abort1 = 1'b0;
            @(negedge CK);
            check("abort_done", {done1, vpos1, valid1}, {1'b1, 9'd0, 1'b0});
            wait_cyc(t + 11);
            @(negedge CK);
            check("abort_idle", busy1, 0);
        end
`endif

        wait_cyc(cyc + 20);
        check("start_queue_empty", sq.size(), 0);
        check("blk_queue_empty", bq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        check("row1_queue_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
